// File: rtl/pine_exec_pkg.sv
// rtl/pine_exec_pkg.sv - micro-op encodings, FSM states and extension helpers for the pine16 execute stage
package pine_exec_pkg;

   localparam logic [1:0] KIND_NOP   = 2'd0;
   localparam logic [1:0] KIND_ALU   = 2'd1;
   localparam logic [1:0] KIND_LOAD  = 2'd2;
   localparam logic [1:0] KIND_STORE = 2'd3;

   localparam logic [3:0] ALU_PASS = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SHL1 = 4'd6;
   localparam logic [3:0] ALU_SHR1 = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MREQ,
      ST_MREL,
      ST_DONE
   } state_e;

   // Helpers work on a 64-bit carrier; msb names the top bit of the source field.
   function automatic logic [63:0] low_mask(input logic [5:0] msb);
      return ~(({64{1'b1}} << msb) << 1);
   endfunction

   function automatic logic [63:0] zext(input logic [63:0] v, input logic [5:0] msb);
      return v & low_mask(msb);
   endfunction

   function automatic logic [63:0] sext(input logic [63:0] v, input logic [5:0] msb);
      logic sign;
      sign = |(v & (64'd1 << msb));
      return sign ? (v | ~low_mask(msb)) : (v & low_mask(msb));
   endfunction

endpackage

// File: rtl/execute_unit_if.sv
// rtl/execute_unit_if.sv - decoder handshake and memory port bundle of the execute stage
interface execute_unit_if #(
   parameter int DW = 16,
   parameter int AW = 20,
   parameter int RW = 4
);
   logic          rqx_p;
   logic          akx_n;
   logic [1:0]    kind;
   logic [3:0]    aluop;
   logic          bsel;
   logic [RW-1:0] rs;
   logic [RW-1:0] rd;
   logic [DW-1:0] imm;
   logic          rqm_n;
   logic          rwm_n;
   logic          akm_n;
   logic [DW-1:0] drm_n;
   logic [DW-1:0] dwm_n;
   logic [AW-1:0] adm_n;
   logic          fault;

   modport slave (
      input  rqx_p, kind, aluop, bsel, rs, rd, imm, akm_n, drm_n,
      output akx_n, rqm_n, rwm_n, dwm_n, adm_n, fault
   );

   modport master (
      output rqx_p, kind, aluop, bsel, rs, rd, imm, akm_n, drm_n,
      input  akx_n, rqm_n, rwm_n, dwm_n, adm_n, fault
   );
endinterface

// File: rtl/exec_regfile.sv
// rtl/exec_regfile.sv - NREG x DW register file, one write port, two asynchronous read ports
module exec_regfile #(
   parameter int DW   = 16,
   parameter int NREG = 16,
   parameter int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [RW-1:0] wa_i,
   input  logic [DW-1:0] wd_i,
   input  logic [RW-1:0] ra0_i,
   output logic [DW-1:0] rd0_o,
   input  logic [RW-1:0] ra1_i,
   output logic [DW-1:0] rd1_o
);

   logic [DW-1:0] regs_q [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd0_o = regs_q[ra0_i];
   assign rd1_o = regs_q[ra1_i];

endmodule

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - pine16 execute stage: ALU, load/store over a 4-phase memory port, timeout fault
module execute_unit
   import pine_exec_pkg::*;
#(
   parameter int DW   = 16,
   parameter int AW   = 20,
   parameter int NREG = 16,
   parameter int TMO  = 255
) (
   input logic           clk,
   input logic           rst,
   execute_unit_if.slave bus
);

   localparam int         RW       = $clog2(NREG);
   localparam logic [5:0] DW_MSB   = 6'(DW - 1);
   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   state_e        state_q, state_d;
   logic [1:0]    kind_q, kind_d;
   logic [3:0]    aluop_q, aluop_d;
   logic          bsel_q, bsel_d;
   logic [RW-1:0] rs_q, rs_d;
   logic [RW-1:0] rd_q, rd_d;
   logic [DW-1:0] imm_q, imm_d;
   logic          akx_q, akx_d;
   logic          rqm_q, rqm_d;
   logic          rwm_q, rwm_d;
   logic [DW-1:0] dwm_q, dwm_d;
   logic [AW-1:0] adm_q, adm_d;
   logic          fault_q, fault_d;
   logic [15:0]   tmo_q, tmo_d;

   logic          rf_we;
   logic [DW-1:0] rf_wd;
   logic [DW-1:0] rs_val;
   logic [DW-1:0] rd_val;
   logic [DW-1:0] op_b;
   logic [DW-1:0] alu_y;
   logic [AW-1:0] mem_addr;

   exec_regfile #(
      .DW   (DW),
      .NREG (NREG),
      .RW   (RW)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we_i  (rf_we),
      .wa_i  (rd_q),
      .wd_i  (rf_wd),
      .ra0_i (rs_q),
      .rd0_o (rs_val),
      .ra1_i (rd_q),
      .rd1_o (rd_val)
   );

   assign op_b     = bsel_q ? imm_q : rs_val;
   assign mem_addr = AW'(zext(64'(rs_val), DW_MSB) + sext(64'(imm_q), DW_MSB));

   always_comb begin
      alu_y = op_b;
      case (aluop_q)
         ALU_ADD:  alu_y = rd_val + op_b;
         ALU_SUB:  alu_y = rd_val - op_b;
         ALU_AND:  alu_y = rd_val & op_b;
         ALU_OR:   alu_y = rd_val | op_b;
         ALU_XOR:  alu_y = rd_val ^ op_b;
         ALU_SHL1: alu_y = op_b << 1;
         ALU_SHR1: alu_y = op_b >> 1;
         default:  alu_y = op_b;
      endcase
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      aluop_d = aluop_q;
      bsel_d  = bsel_q;
      rs_d    = rs_q;
      rd_d    = rd_q;
      imm_d   = imm_q;
      akx_d   = 1'b0;
      rqm_d   = rqm_q;
      rwm_d   = rwm_q;
      dwm_d   = dwm_q;
      adm_d   = adm_q;
      fault_d = fault_q;
      tmo_d   = tmo_q;
      rf_we   = 1'b0;
      rf_wd   = alu_y;

      case (state_q)
         ST_IDLE: begin
            // akx_q is still high on the cycle after DONE; the held request must not re-enter.
            if (bus.rqx_p && !akx_q) begin
               kind_d  = bus.kind;
               aluop_d = bus.aluop;
               bsel_d  = bus.bsel;
               rs_d    = bus.rs;
               rd_d    = bus.rd;
               imm_d   = bus.imm;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (kind_q)
               KIND_NOP: state_d = ST_DONE;
               KIND_ALU: begin
                  rf_we   = 1'b1;
                  state_d = ST_DONE;
               end
               default: begin
                  adm_d   = mem_addr;
                  rwm_d   = (kind_q == KIND_STORE);
                  dwm_d   = rd_val;
                  rqm_d   = 1'b1;
                  tmo_d   = '0;
                  state_d = ST_MREQ;
               end
            endcase
         end
         ST_MREQ: begin
            if (bus.akm_n) begin
               rqm_d   = 1'b0;
               rf_we   = (kind_q == KIND_LOAD);
               rf_wd   = bus.drm_n;
               tmo_d   = '0;
               state_d = ST_MREL;
            end else if (tmo_q == TMO_LAST) begin
               fault_d = 1'b1;
               rqm_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ST_MREL: begin
            if (!bus.akm_n) begin
               state_d = ST_DONE;
            end else if (tmo_q == TMO_LAST) begin
               fault_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ST_DONE: begin
            akx_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kind_q  <= KIND_NOP;
         aluop_q <= ALU_PASS;
         bsel_q  <= 1'b0;
         rs_q    <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         akx_q   <= 1'b0;
         rqm_q   <= 1'b0;
         rwm_q   <= 1'b0;
         dwm_q   <= '0;
         adm_q   <= '0;
         fault_q <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         aluop_q <= aluop_d;
         bsel_q  <= bsel_d;
         rs_q    <= rs_d;
         rd_q    <= rd_d;
         imm_q   <= imm_d;
         akx_q   <= akx_d;
         rqm_q   <= rqm_d;
         rwm_q   <= rwm_d;
         dwm_q   <= dwm_d;
         adm_q   <= adm_d;
         fault_q <= fault_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.akx_n = akx_q;
   assign bus.rqm_n = rqm_q;
   assign bus.rwm_n = rwm_q;
   assign bus.dwm_n = dwm_q;
   assign bus.adm_n = adm_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed, table-driven bench for execute_unit
module tb_execute_unit;
   import pine_exec_pkg::*;

   localparam int DW   = 16;
   localparam int AW   = 20;
   localparam int NREG = 16;
   localparam int RW   = 4;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   execute_unit_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

   execute_unit #(
      .DW   (DW),
      .AW   (AW),
      .NREG (NREG),
      .TMO  (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory responder: acks after mem_delay cycles of request, releases once rqm_n drops.
   bit            mem_en    = 1'b1;
   int            mem_delay = 0;
   logic [15:0]   mem_rdata = '0;
   int            rcnt      = 0;
   int            ack_cyc   = 0;
   int            fall_cyc  = 0;
   int            rqm_len   = 0;
   bit            unstable  = 1'b0;
   logic [AW-1:0] cap_adm   = '0;
   logic [DW-1:0] cap_dwm   = '0;
   logic          cap_rwm   = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         bus.akm_n = 1'b0;
         bus.drm_n = '0;
         rcnt      = 0;
      end else if (bus.akm_n) begin
         if (!bus.rqm_n) begin
            bus.akm_n = 1'b0;
            fall_cyc  = cyc;
            rcnt      = 0;
         end
      end else if (bus.rqm_n) begin
         if (rcnt == 0) begin
            cap_adm = bus.adm_n;
            cap_dwm = bus.dwm_n;
            cap_rwm = bus.rwm_n;
         end else if (bus.adm_n !== cap_adm || bus.dwm_n !== cap_dwm || bus.rwm_n !== cap_rwm) begin
            unstable = 1'b1;
         end
         rcnt++;
         if (mem_en && rcnt > mem_delay) begin
            bus.akm_n = 1'b1;
            bus.drm_n = mem_rdata;
            ack_cyc   = cyc;
         end
      end else if (rcnt != 0) begin
         rqm_len = rcnt;
         rcnt    = 0;
      end
   end

   int akx_cyc = 0;

   task automatic do_op(input logic [1:0] k, input logic [3:0] op, input logic bs,
                        input logic [3:0] s, input logic [3:0] d, input logic [15:0] im,
                        output int lat);
      @(negedge clk);
      bus.kind  = k;
      bus.aluop = op;
      bus.bsel  = bs;
      bus.rs    = s;
      bus.rd    = d;
      bus.imm   = im;
      bus.rqx_p = 1'b1;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (bus.akx_n) begin
            lat = n - 1;
            break;
         end
      end
      akx_cyc   = cyc;
      bus.rqx_p = 1'b0;
      check("akx_seen", 32'(lat >= 0), 32'd1);
      @(negedge clk);
      check("akx_one_cycle", 32'(bus.akx_n), 32'd0);
   endtask

   task automatic read_reg(input logic [3:0] r, output logic [15:0] v);
      int lat;
      mem_en    = 1'b1;
      mem_delay = 0;
      do_op(KIND_STORE, ALU_PASS, 1'b0, 4'd0, r, 16'h0000, lat);
      v = cap_dwm;
   endtask

   typedef struct {
      logic [1:0]  k;
      logic [3:0]  op;
      logic        bs;
      logic [3:0]  s;
      logic [3:0]  d;
      logic [15:0] im;
      logic [15:0] exp;
   } vec_t;

   vec_t tv [18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [15:0] v;

      tv[0]  = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd3, 16'h0010, 16'h0010};
      tv[1]  = '{KIND_ALU, ALU_ADD,  1'b1, 4'd0, 4'd3, 16'h0005, 16'h0015};
      tv[2]  = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd2, 16'h0001, 16'h0001};
      tv[3]  = '{KIND_ALU, ALU_SUB,  1'b0, 4'd2, 4'd1, 16'h0000, 16'hFFFF};
      tv[4]  = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd4, 16'h1000, 16'h1000};
      tv[5]  = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd5, 16'hBEEF, 16'hBEEF};
      tv[6]  = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd6, 16'hF0F0, 16'hF0F0};
      tv[7]  = '{KIND_ALU, ALU_AND,  1'b1, 4'd0, 4'd6, 16'h0FF0, 16'h00F0};
      tv[8]  = '{KIND_ALU, ALU_OR,   1'b1, 4'd0, 4'd6, 16'h0F00, 16'h0FF0};
      tv[9]  = '{KIND_ALU, ALU_XOR,  1'b1, 4'd0, 4'd6, 16'hFFFF, 16'hF00F};
      tv[10] = '{KIND_ALU, ALU_SHL1, 1'b0, 4'd5, 4'd6, 16'h0000, 16'h7DDE};
      tv[11] = '{KIND_ALU, ALU_SHR1, 1'b0, 4'd5, 4'd6, 16'h0000, 16'h5F77};
      tv[12] = '{KIND_ALU, 4'hC,     1'b1, 4'd0, 4'd6, 16'h1234, 16'h1234};
      tv[13] = '{KIND_NOP, ALU_ADD,  1'b1, 4'd0, 4'd6, 16'hABCD, 16'h1234};
      tv[14] = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd8, 16'hFFFF, 16'hFFFF};
      tv[15] = '{KIND_ALU, ALU_ADD,  1'b1, 4'd0, 4'd8, 16'h0002, 16'h0001};
      tv[16] = '{KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd0, 16'h0020, 16'h0020};
      tv[17] = '{KIND_ALU, ALU_ADD,  1'b0, 4'd3, 4'd9, 16'h0000, 16'h0015};

      bus.rqx_p = 1'b0;
      bus.kind  = KIND_NOP;
      bus.aluop = ALU_PASS;
      bus.bsel  = 1'b0;
      bus.rs    = '0;
      bus.rd    = '0;
      bus.imm   = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_akx",   32'(bus.akx_n), 32'd0);
      check("rst_rqm",   32'(bus.rqm_n), 32'd0);
      check("rst_rwm",   32'(bus.rwm_n), 32'd0);
      check("rst_dwm",   32'(bus.dwm_n), 32'd0);
      check("rst_adm",   32'(bus.adm_n), 32'd0);
      check("rst_fault", 32'(bus.fault), 32'd0);

      for (int i = 0; i < 18; i++) begin
         do_op(tv[i].k, tv[i].op, tv[i].bs, tv[i].s, tv[i].d, tv[i].im, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         read_reg(tv[i].d, v);
         check($sformatf("vec%0d_value", i), 32'(v), 32'(tv[i].exp));
      end

      // Store with three wait cycles before the memory acks.
      mem_en    = 1'b1;
      mem_delay = 3;
      unstable  = 1'b0;
      do_op(KIND_STORE, ALU_PASS, 1'b0, 4'd4, 4'd5, 16'hFFFE, lat);
      check("st_adm",      32'(cap_adm),  32'h00FFE);
      check("st_rwm",      32'(cap_rwm),  32'd1);
      check("st_dwm",      32'(cap_dwm),  32'hBEEF);
      check("st_stable",   32'(unstable), 32'd0);
      check("st_rqm_drop", 32'(fall_cyc - ack_cyc), 32'd1);
      check("st_akx_after_akm", 32'(akx_cyc - fall_cyc), 32'd2);
      check("st_fault",    32'(bus.fault), 32'd0);

      mem_delay = 1;
      mem_rdata = 16'h1234;
      do_op(KIND_LOAD, ALU_PASS, 1'b0, 4'd0, 4'd7, 16'h0004, lat);
      check("ld_adm", 32'(cap_adm), 32'h00024);
      check("ld_rwm", 32'(cap_rwm), 32'd0);
      read_reg(4'd7, v);
      check("ld_r7",    32'(v), 32'h1234);
      check("ld_fault", 32'(bus.fault), 32'd0);

      // Negative offset sign-extends across the upper address bits.
      do_op(KIND_STORE, ALU_PASS, 1'b0, 4'd8, 4'd6, 16'h8000, lat);
      check("addr_sext", 32'(cap_adm), 32'hF8001);

      // Timeout: memory never acks.
      mem_en  = 1'b0;
      rqm_len = 0;
      do_op(KIND_LOAD, ALU_PASS, 1'b0, 4'd0, 4'd7, 16'h0000, lat);
      check("tmo_rqm_len", 32'(rqm_len), 32'(TMO));
      check("tmo_fault",   32'(bus.fault), 32'd1);
      mem_en = 1'b1;
      read_reg(4'd7, v);
      check("tmo_r7_kept", 32'(v), 32'h1234);
      do_op(KIND_ALU, ALU_PASS, 1'b1, 4'd0, 4'd9, 16'h0055, lat);
      check("post_fault_lat", 32'(lat), 32'd2);
      read_reg(4'd9, v);
      check("post_fault_r9",    32'(v), 32'h0055);
      check("fault_sticky",     32'(bus.fault), 32'd1);

      // Reset while a load is waiting in MREQ, with a new request held through reset.
      mem_en = 1'b0;
      @(negedge clk);
      bus.kind  = KIND_LOAD;
      bus.rs    = 4'd0;
      bus.rd    = 4'd7;
      bus.imm   = 16'h0000;
      bus.rqx_p = 1'b1;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.rqm_n) begin
            lat = n;
            break;
         end
      end
      check("rmid_in_mreq", 32'(lat > 0), 32'd1);
      bus.kind  = KIND_ALU;
      bus.aluop = ALU_ADD;
      bus.bsel  = 1'b1;
      bus.rd    = 4'd10;
      bus.imm   = 16'h0003;
      rst = 1'b1;
      @(negedge clk);
      check("rmid_rqm",   32'(bus.rqm_n), 32'd0);
      check("rmid_akx",   32'(bus.akx_n), 32'd0);
      check("rmid_fault", 32'(bus.fault), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rmid_held_rqm", 32'(bus.rqm_n), 32'd0);
         check("rmid_held_akx", 32'(bus.akx_n), 32'd0);
      end
      rst    = 1'b0;
      mem_en = 1'b1;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.akx_n) begin
            lat = n - 1;
            break;
         end
      end
      bus.rqx_p = 1'b0;
      check("rmid_accept_lat", 32'(lat), 32'd2);
      read_reg(4'd10, v);
      check("rmid_r10", 32'(v), 32'h0003);
      read_reg(4'd4, v);
      check("rmid_r4_clr", 32'(v), 32'h0000);
      read_reg(4'd7, v);
      check("rmid_r7_clr", 32'(v), 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Parametrised next-generation execute stage of the pine16 CPU; sits between the decoder and the memory arbiter.
- Accepts one micro-op per handshake from the decoder and executes it: ALU op, load, store or NOP.
- Owns the register file and a small internal ALU.
- Drives a 4-phase request/acknowledge memory port, with a wait-state timeout and a fault output.

Parameters:
- DW, 16, datapath / register width in bits.
- AW, 20, memory address width in bits (AW >= DW).
- NREG, 16, number of general registers (power of two, >= 2).
- TMO, 255, max cycles waiting on akm_n per memory phase before fault (1..65535).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- rqx_p  in  1  decoder request; micro-op fields valid while high.
- akx_n  out  1  execute acknowledge; high one cycle when the micro-op retires or faults.
- kind  in  2  0 NOP, 1 ALU, 2 LOAD, 3 STORE.
- aluop  in  4  ALU function (0 PASS-B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL1, 7 SHR1, others PASS-B).
- bsel  in  1  ALU B operand: 0 register rs, 1 imm.
- rs, rd  in  log2(NREG)  source / destination register.
- imm  in  DW  immediate; sign-extended to AW for address offsets.
- rqm_n  out  1  memory request.
- rwm_n  out  1  1 write, 0 read; valid while rqm_n high.
- akm_n  in  1  memory acknowledge.
- drm_n  in  DW  read data, sampled on the cycle akm_n is first seen high.
- dwm_n  out  DW  write data.
- adm_n  out  AW  address.
- fault  out  1  sticky; set on memory timeout, cleared only by rst.

Behaviour:
- Reset: FSM to IDLE; akx_n=0, rqm_n=0, rwm_n=0, dwm_n=0, adm_n=0, fault=0; all registers cleared to 0.
  - Reset mid-operation drops rqm_n next cycle with no writeback.
- FSM states: IDLE, EXEC, MREQ, MREL, DONE.
- IDLE: on rqx_p=1 (and akx_n=0), latch all fields and go to EXEC. rqx_p is ignored in every other state.
- EXEC:
  - Operand A = reg[rd]; B = bsel ? imm : reg[rs].
  - NOP: go to DONE.
  - ALU: reg[rd] <= f(A, B) truncated to DW; go to DONE.
    - SHL1/SHR1 act on B and fill with 0.
  - LOAD/STORE: adm_n <= zext(reg[rs]) + sext(imm), modulo 2^AW; rwm_n <= (kind==STORE); dwm_n <= reg[rd]; rqm_n <= 1; go to MREQ.
- MREQ:
  - Hold rqm_n=1 and adm_n/dwm_n/rwm_n stable.
  - On akm_n=1: rqm_n <= 0; if LOAD, reg[rd] <= drm_n; go to MREL.
- MREL: wait for akm_n=0, then go to DONE.
- Timeout:
  - A counter resets on entry to MREQ and again on entry to MREL.
  - If it reaches TMO without the awaited akm_n edge: fault <= 1, rqm_n <= 0, no writeback, go to DONE.
- DONE: akx_n=1 for exactly one cycle, then IDLE.
  - Minimum latency: ALU/NOP ack 2 cycles after accept; memory ack 3 cycles + 2 handshake waits.
- Register file:
  - Write port 1, async read ports 2 (rs, rd).
  - reg[0] is an ordinary register (not hardwired zero).
- Forwarding: none. Back-to-back micro-ops are serialised by the handshake, so reads always observe the prior writeback.
- An akm_n already high on MREQ entry is legal; it completes MREQ on that cycle.
- After a fault, new micro-ops are still accepted and executed.

Decomposition:
- Package pine_exec_pkg: kind encodings (KIND_NOP/ALU/LOAD/STORE), ALU op constants, FSM state enum, sext/zext helper function.
- One sub-module: exec_regfile (NREG x DW, 1W2R, synchronous reset clear).
- The ALU stays inline as a combinational case.

Test Plan:
- ALU immediate: ALU ADD rd=3 bsel=1 imm=0x0005 with r3=0x0010 -> r3=0x0015; akx_n pulses 2 cycles after accept.
- Wrap-around: ALU SUB rd=1 rs=2 bsel=0 with r1=0x0000, r2=0x0001 -> r1=0xFFFF.
- Store address: STORE rs=4 (0x1000) imm=0xFFFE rd=5 (0xBEEF), akm_n high after 3 cycles -> adm_n=0x00FFE, rwm_n=1, dwm_n=0xBEEF; rqm_n drops the cycle after akm_n; akx_n follows akm_n low.
- Load: LOAD rd=7 rs=0 (0x0020) imm=0x0004, memory returns 0x1234 -> adm_n=0x00024, r7=0x1234, fault=0.
- Timeout: LOAD with akm_n held low and TMO=8 -> rqm_n falls at cycle 8 of MREQ, fault=1, rd unchanged, akx_n pulses; a following ALU op still executes.
- Reset mid-op: assert rst while in MREQ -> next cycle rqm_n=0, akx_n=0, all registers 0, FSM IDLE; rqx_p held during rst is not accepted until rst falls.
